// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg: shared widths, zero-register constant and the writeback entry type
package wb_write_arbiter_pkg;
  localparam int XLEN = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;
  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_arbiter_fifo.sv
// wb_fifo: DEPTH-entry load-result FIFO with per-entry valid/rd for hazard compare (clk, rst active-low async, push/din, pop/head, full/empty, vld/rds)
module wb_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push,
  input  logic                                  pop,
  input  wb_entry_t                             din,
  output logic                                  full,
  output logic                                  empty,
  output wb_entry_t                             head,
  output logic [DEPTH-1:0]                      vld,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]      rds
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wp, rp;
  wb_entry_t mem [DEPTH];
  logic do_push, do_pop;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign head = mem[rp[AW-1:0]];
  for (genvar i = 0; i < DEPTH; i++) begin : g_rd
    assign rds[i] = mem[i].rd;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp <= '0;
      rp <= '0;
      vld <= '0;
    end else begin
      if (do_push) begin
        wp <= wp + PW'(1);
        vld[wp[AW-1:0]] <= 1'b1;
      end
      if (do_pop) begin
        rp <= rp + PW'(1);
        vld[rp[AW-1:0]] <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (do_push) mem[wp[AW-1:0]] <= din;
  end
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges ALU and buffered load results onto the register-file write port
// Ports: clk; rst (async, active-low); alu_valid/alu_ready/alu_rd/alu_data (ALU result);
//        ld_valid/ld_ready/ld_rd/ld_data (load result into FIFO); hz_addr/hz_pending (decode query);
//        WE3/A3/WD3 (registered register-file write port).
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int MAX_WAIT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_rd,
  input  logic [XLEN-1:0]       alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_rd,
  input  logic [XLEN-1:0]       ld_data,
  input  logic [REG_ADDR_W-1:0] hz_addr,
  output logic                  hz_pending,
  output logic                  WE3,
  output logic [REG_ADDR_W-1:0] A3,
  output logic [XLEN-1:0]       WD3
);
  localparam int CW = $clog2(MAX_WAIT + 2);
  logic full, empty, push, pop, alu_wr, ld_fire, fd_clr, hit, force_drain;
  wb_entry_t head;
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0][REG_ADDR_W-1:0] rds;
  logic [CW-1:0] cnt;
  assign ld_ready = !full;
  assign alu_ready = !force_drain;
  assign ld_fire = ld_valid && ld_ready;
  assign push = ld_fire && (ld_rd != ZERO_REG);
  assign alu_wr = alu_valid && alu_ready && (alu_rd != ZERO_REG);
  assign pop = !alu_wr && !empty;
  // force_drain drops on the edge where the FIFO goes empty, not one cycle later
  assign fd_clr = !push && (empty || (pop && $countones(vld) == 1));
  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .din('{rd: ld_rd, data: ld_data}),
    .full(full),
    .empty(empty),
    .head(head),
    .vld(vld),
    .rds(rds)
  );
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) hit |= vld[i] && (rds[i] == hz_addr);
  end
  assign hz_pending = (hz_addr != ZERO_REG) && (hit || (WE3 && A3 == hz_addr) ||
                      (ld_fire && ld_rd == hz_addr) || (alu_wr && alu_rd == hz_addr));
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      force_drain <= 1'b0;
    end else begin
      cnt <= (empty || pop) ? '0 : cnt + CW'(1);
      force_drain <= fd_clr ? 1'b0 : (cnt >= CW'(MAX_WAIT)) ? 1'b1 : force_drain;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      WE3 <= 1'b0;
      A3 <= ZERO_REG;
      WD3 <= '0;
    end else begin
      WE3 <= alu_wr || pop;
      if (alu_wr) begin
        A3 <= alu_rd;
        WD3 <= alu_data;
      end else if (pop) begin
        A3 <= head.rd;
        WD3 <= head.data;
      end
    end
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed and randomized checks of wb_write_arbiter against a queue-based model
module tb_wb_write_arbiter;
  logic clk = 0, rst;
  logic alu_valid, ld_valid, alu_ready, ld_ready, hz_pending, WE3;
  logic [4:0] alu_rd, ld_rd, hz_addr, A3;
  logic [31:0] alu_data, ld_data, WD3;
  int total = 0, bad = 0;
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t q[$];
  int m_cnt;
  bit m_fd, m_we, a_st, l_st;
  logic [4:0] m_a3;
  logic [31:0] m_wd;

  wb_write_arbiter dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_rd(ld_rd), .ld_data(ld_data),
    .hz_addr(hz_addr), .hz_pending(hz_pending),
    .WE3(WE3), .A3(A3), .WD3(WD3)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic m_reset();
    q.delete();
    m_cnt = 0;
    m_fd = 0;
    m_we = 0;
    m_a3 = 0;
    m_wd = 0;
  endtask

  task automatic step();
    bit aw, lt, pop, pend;
    int n;
    #4;
    lt = ld_valid && q.size() < 4;
    aw = alu_valid && !m_fd && alu_rd != 0;
    pend = 0;
    if (hz_addr != 0) begin
      foreach (q[i]) if (q[i].rd == hz_addr) pend = 1;
      if (m_we && m_a3 == hz_addr) pend = 1;
      if (lt && ld_rd == hz_addr) pend = 1;
      if (aw && alu_rd == hz_addr) pend = 1;
    end
    chk("ld_ready", ld_ready, q.size() < 4);
    chk("alu_ready", alu_ready, !m_fd);
    chk("hz_pending", hz_pending, pend);
    chk("we3", WE3, m_we);
    chk("a3", A3, m_a3);
    chk("wd3", WD3, m_wd);
    a_st = alu_valid && !m_fd;
    a_st = alu_valid && !a_st;
    l_st = ld_valid && !lt;
    pop = !aw && q.size() > 0;
    if (aw) begin
      m_we = 1; m_a3 = alu_rd; m_wd = alu_data;
    end else if (pop) begin
      m_we = 1; m_a3 = q[0].rd; m_wd = q[0].d;
    end else m_we = 0;
    n = q.size() - int'(pop) + int'(lt && ld_rd != 0);
    if (n == 0) m_fd = 0;
    else if (m_cnt >= 8) m_fd = 1;
    m_cnt = (q.size() == 0 || pop) ? 0 : m_cnt + 1;
    if (pop) void'(q.pop_front());
    if (lt && ld_rd != 0) q.push_back('{ld_rd, ld_data});
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alu_valid = 0; ld_valid = 0; hz_addr = 0;
    alu_rd = 0; ld_rd = 0; alu_data = 0; ld_data = 0;
  endtask

  task automatic drain();
    int k = 0;
    idle();
    while ((q.size() > 0 || m_fd) && k < 40) begin step(); k++; end
    chk("drain_bound", k < 40, 1);
  endtask

  initial begin
    int k;
    logic [4:0] hz_list [4] = '{5'd7, 5'd8, 5'd6, 5'd9};
    idle();
    rst = 0;
    m_reset();
    #1;
    chk("rst_we3", WE3, 0);
    chk("rst_a3", A3, 0);
    chk("rst_wd3", WD3, 0);
    @(posedge clk); #1;
    rst = 1;
    step();

    alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
    step();
    chk("alu_we3", WE3, 1); chk("alu_a3", A3, 5); chk("alu_wd3", WD3, 32'hDEADBEEF);
    alu_rd = 0;
    step();
    chk("alu_r0_we3", WE3, 0); chk("alu_r0_a3_hold", A3, 5);
    idle();
    step();

    alu_valid = 1; alu_rd = 3; alu_data = 32'h11;
    ld_valid = 1; ld_rd = 4; ld_data = 32'h22;
    step();
    idle();
    chk("col_a3", A3, 3); chk("col_wd3", WD3, 32'h11); chk("col_we3", WE3, 1);
    step();
    chk("col2_a3", A3, 4); chk("col2_wd3", WD3, 32'h22); chk("col2_we3", WE3, 1);
    step();

    alu_valid = 1; alu_rd = 9; alu_data = 32'h99;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1; ld_rd = 5'(i + 1); ld_data = 32'h100 + i;
      step();
    end
    chk("full_ready", ld_ready, 0);
    ld_rd = 5; ld_data = 32'h105;
    k = 0;
    while (!ld_ready && k < 30) begin step(); k++; end
    chk("full_wait", k, 7);
    step();
    drain();

    alu_valid = 1; alu_rd = 9; alu_data = 32'h55;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1; ld_rd = hz_list[i]; ld_data = 32'h200 + i;
      step();
    end
    ld_valid = 0;
    chk("pre_rst_we3", WE3, 1);
    #2;
    rst = 0;
    alu_valid = 0;
    #1;
    chk("arst_we3", WE3, 0); chk("arst_a3", A3, 0); chk("arst_wd3", WD3, 0);
    chk("arst_ld_ready", ld_ready, 1);
    foreach (hz_list[i]) begin
      hz_addr = hz_list[i];
      #1;
      chk("arst_hz", hz_pending, 0);
    end
    m_reset();
    idle();
    @(posedge clk); #1;
    rst = 1;
    step();

    alu_valid = 1; alu_rd = 10; alu_data = 32'hA1;
    ld_valid = 1; ld_rd = 12; ld_data = 32'hABCD;
    step();
    ld_valid = 0;
    k = 1;
    while (alu_ready && k < 40) begin step(); k++; end
    chk("starve_cycles", k, 10);
    step();
    chk("starve_we3", WE3, 1); chk("starve_a3", A3, 12); chk("starve_wd3", WD3, 32'hABCD);
    chk("starve_alu_ready", alu_ready, 1);
    drain();

    alu_valid = 1; alu_rd = 9; alu_data = 32'h9;
    ld_valid = 1; ld_rd = 7; ld_data = 32'h77;
    step();
    ld_valid = 0;
    hz_addr = 7; #1;
    chk("hz_buf", hz_pending, 1);
    hz_addr = 0; #1;
    chk("hz_zero", hz_pending, 0);
    hz_addr = 7; alu_valid = 0;
    step();
    chk("hz_we3", WE3, 1); chk("hz_a3", A3, 7);
    #1;
    chk("hz_wr", hz_pending, 1);
    step();
    chk("hz_we3_off", WE3, 0);
    #1;
    chk("hz_drop", hz_pending, 0);
    drain();

    a_st = 0; l_st = 0;
    for (int c = 0; c < 800; c++) begin
      if (!a_st) begin
        alu_valid = $urandom_range(0, 9) < 6;
        alu_rd = 5'($urandom_range(0, 7));
        alu_data = $urandom;
      end
      if (!l_st) begin
        ld_valid = $urandom_range(0, 1);
        ld_rd = 5'($urandom_range(0, 7));
        ld_data = $urandom;
      end
      hz_addr = 5'($urandom_range(0, 7));
      step();
    end
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
